// File: rtl/uart_bus_ctrl.sv
// Memory-mapped UART front end: CPU register file (TXD/RXD/CON), an RX byte FIFO and
// a TX handshake state machine with one byte of holding buffer.
module uart_bus_ctrl #(
    parameter int unsigned RX_DEPTH = 4,
    parameter logic [31:0] BASE     = 32'h40000018
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        wr,
    input  logic        rd,
    output logic [31:0] rdata,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        tx_busy,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    output logic        irq
);

    localparam int unsigned PW = $clog2(RX_DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(RX_DEPTH);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] START     = 2'd1;
    localparam logic [1:0] WAIT_ACK  = 2'd2;
    localparam logic [1:0] WAIT_DONE = 2'd3;

    logic [7:0]    fifo_q [RX_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q;
    logic          rx_ie_q, tx_ie_q, tx_done_q, rx_ovr_q, tx_full_q;
    logic [7:0]    hold_q, tx_data_q;
    logic [1:0]    state_q, state_d;

    logic sel_txd, sel_rxd, sel_con;
    logic rx_avail, rx_full, pop, push, ovr_set;
    logic con_we, txd_accept, tx_done_set, start_tx;
    logic [31:0] con_val;

    assign sel_txd = (addr == BASE);
    assign sel_rxd = (addr == BASE + 32'd4);
    assign sel_con = (addr == BASE + 32'd8);

    assign rx_avail = (count_q != '0);
    assign rx_full  = (count_q == FULL_CNT);
    assign pop      = rd & sel_rxd & rx_avail;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
    assign push     = rx_valid & (~rx_full | pop);
    assign ovr_set  = rx_valid & rx_full & ~pop;

    assign con_we      = wr & sel_con;
    assign txd_accept  = wr & sel_txd & ~tx_full_q;
    assign tx_done_set = (state_q == WAIT_DONE) & ~tx_busy;
    assign start_tx    = (state_q == IDLE) & (state_d == START);

    assign con_val = {26'b0, rx_ovr_q, tx_full_q, rx_avail, tx_done_q, tx_ie_q, rx_ie_q};

    always_comb begin
        rdata = 32'b0;
        if (rd) begin
            if (sel_txd)                  rdata = {24'b0, hold_q};
            else if (sel_rxd && rx_avail) rdata = {24'b0, fifo_q[rd_ptr_q]};
            else if (sel_con)             rdata = con_val;
        end
    end

    always_ff @(posedge sysclk) begin
        if (push) fifo_q[wr_ptr_q] <= rx_data;
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (push && !pop)      count_q <= count_q + (PW + 1)'(1);
            else if (pop && !push) count_q <= count_q - (PW + 1)'(1);
        end
    end

    // TXD write while idle goes straight to START so tx_start follows the write by one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (!tx_busy && (tx_full_q || txd_accept)) state_d = START;
            START:     state_d = WAIT_ACK;
            WAIT_ACK:  if (tx_busy) state_d = WAIT_DONE;
            WAIT_DONE: if (!tx_busy) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            hold_q    <= 8'b0;
            tx_data_q <= 8'b0;
            tx_full_q <= 1'b0;
            rx_ie_q   <= 1'b0;
            tx_ie_q   <= 1'b0;
            tx_done_q <= 1'b0;
            rx_ovr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (txd_accept) hold_q <= wdata[7:0];
            if (start_tx)   tx_data_q <= tx_full_q ? hold_q : wdata[7:0];
            if (txd_accept)             tx_full_q <= 1'b1;
            else if (state_q == START)  tx_full_q <= 1'b0;
            if (con_we) begin
                rx_ie_q <= wdata[0];
                tx_ie_q <= wdata[1];
            end
            // Set events win over a coincident write-1-to-clear.
            if (tx_done_set)              tx_done_q <= 1'b1;
            else if (con_we && wdata[2])  tx_done_q <= 1'b0;
            if (ovr_set)                  rx_ovr_q <= 1'b1;
            else if (con_we && wdata[5])  rx_ovr_q <= 1'b0;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_start = (state_q == START);
    assign irq      = (rx_ie_q & rx_avail) | (tx_ie_q & tx_done_q);

endmodule

// File: tb/tb_uart_bus_ctrl.sv
// Directed and randomized checks of uart_bus_ctrl against a queue-based reference model.
module tb_uart_bus_ctrl;

    localparam logic [31:0] BASE  = 32'h40000018;
    localparam logic [31:0] TXD   = BASE;
    localparam logic [31:0] RXD   = BASE + 32'd4;
    localparam logic [31:0] CON   = BASE + 32'd8;
    localparam int          DEPTH = 4;

    logic        sysclk = 1'b0;
    logic        reset;
    logic [31:0] addr, wdata, rdata;
    logic        wr, rd, rx_valid, tx_busy, tx_start, irq;
    logic [7:0]  rx_data, tx_data;

    int checks = 0;
    int failures = 0;

    uart_bus_ctrl #(.RX_DEPTH(DEPTH), .BASE(BASE)) dut (
        .sysclk   (sysclk),
        .reset    (reset),
        .addr     (addr),
        .wdata    (wdata),
        .wr       (wr),
        .rd       (rd),
        .rdata    (rdata),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_busy  (tx_busy),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .irq      (irq)
    );

    always #5 sysclk = ~sysclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    // Combinational read without a clock edge, so nothing is popped.
    task automatic peek(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        rd   = 1'b1;
        #1;
        d  = rdata;
        rd = 1'b0;
    endtask

    task automatic rd_reg(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        rd   = 1'b1;
        #1;
        d = rdata;
        tick();
        rd = 1'b0;
    endtask

    task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wr    = 1'b1;
        tick();
        wr = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  exp_bytes [4];
        logic [7:0]  q [$];
        bit          ovr;

        reset = 1'b1; addr = '0; wdata = '0; wr = 0; rd = 0;
        rx_data = '0; rx_valid = 0; tx_busy = 0;
        tick(); tick();
        chk("reset_tx_start", 32'(tx_start), 32'h0);
        chk("reset_irq", 32'(irq), 32'h0);
        chk("reset_tx_data", 32'(tx_data), 32'h0);
        peek(CON, d); chk("reset_con", d, 32'h0);
        reset = 1'b0;
        tick();

        // RX ordering
        push(8'h96); push(8'hB9); push(8'h1E);
        peek(CON, d); chk("rx_avail_set", d, 32'h08);
        exp_bytes = '{8'h96, 8'hB9, 8'h1E, 8'h00};
        for (int i = 0; i < 4; i++) begin
            rd_reg(RXD, d); chk($sformatf("rx_order_%0d", i), d, 32'(exp_bytes[i]));
        end
        peek(CON, d); chk("rx_empty_con", d, 32'h0);

        // Overrun
        for (int i = 1; i <= 5; i++) push(8'(i));
        peek(CON, d); chk("ovr_con", d, 32'h28);
        for (int i = 1; i <= 4; i++) begin
            rd_reg(RXD, d); chk($sformatf("ovr_read_%0d", i), d, 32'(i));
        end
        peek(CON, d); chk("ovr_sticky", d, 32'h20);
        wr_reg(CON, 32'h20);
        peek(CON, d); chk("ovr_clear", d, 32'h0);

        // Simultaneous push and pop on a full FIFO
        for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
        addr = RXD; rd = 1; rx_data = 8'h7E; rx_valid = 1;
        #1; d = rdata;
        tick();
        rd = 0; rx_valid = 0;
        chk("pp_head", d, 32'hA0);
        peek(CON, d); chk("pp_no_ovr", d, 32'h08);
        exp_bytes = '{8'hA1, 8'hA2, 8'hA3, 8'h7E};
        for (int i = 0; i < 4; i++) begin
            rd_reg(RXD, d); chk($sformatf("pp_order_%0d", i), d, 32'(exp_bytes[i]));
        end

        // TX sequencing
        wr_reg(CON, 32'h02);
        chk("tx_idle_start", 32'(tx_start), 32'h0);
        wr_reg(TXD, 32'h69);
        chk("tx_start_pulse", 32'(tx_start), 32'h1);
        chk("tx_start_data", 32'(tx_data), 32'h69);
        tick();
        chk("tx_start_one_cycle", 32'(tx_start), 32'h0);
        peek(CON, d); chk("tx_full_cleared", d, 32'h02);
        tx_busy = 1;
        repeat (9) tick();
        peek(CON, d); chk("tx_no_done_busy", d, 32'h02);
        chk("tx_irq_busy", 32'(irq), 32'h0);
        tick();
        tx_busy = 0;
        tick();
        peek(CON, d); chk("tx_done_set", d, 32'h06);
        chk("tx_irq_ie", 32'(irq), 32'h1);
        wr_reg(CON, 32'h00);
        peek(CON, d); chk("tx_done_sticky", d, 32'h04);
        chk("tx_irq_no_ie", 32'(irq), 32'h0);
        wr_reg(CON, 32'h04);
        peek(CON, d); chk("tx_done_w1c", d, 32'h0);

        // Double buffering
        wr_reg(TXD, 32'h69);
        tick();
        tx_busy = 1;
        tick();
        wr_reg(TXD, 32'h46);
        peek(CON, d); chk("db_full", d, 32'h10);
        wr_reg(TXD, 32'hAA);
        peek(TXD, d); chk("db_ignored", d, 32'h46);
        for (int i = 0; i < 5; i++) begin
            tick(); chk($sformatf("db_wait_%0d", i), 32'(tx_start), 32'h0);
        end
        tx_busy = 0;
        tick();
        chk("db_no_early_start", 32'(tx_start), 32'h0);
        chk("db_data_held", 32'(tx_data), 32'h69);
        tick();
        chk("db_second_start", 32'(tx_start), 32'h1);
        chk("db_second_data", 32'(tx_data), 32'h46);
        tick();
        peek(CON, d); chk("db_after_start", d, 32'h04);
        tx_busy = 1; tick();
        tx_busy = 0; tick();
        wr_reg(CON, 32'h04);

        // Set beats coincident clear
        for (int i = 0; i < 4; i++) push(8'hB0 + 8'(i));
        addr = CON; wdata = 32'h20; wr = 1; rx_data = 8'hFF; rx_valid = 1;
        tick();
        wr = 0; rx_valid = 0;
        peek(CON, d); chk("ovr_set_priority", d, 32'h28);

        // Reset mid-transmission with two bytes queued
        wr_reg(CON, 32'h21);
        rd_reg(RXD, d); chk("pre_reset_b0", d, 32'hB0);
        rd_reg(RXD, d); chk("pre_reset_b1", d, 32'hB1);
        wr_reg(TXD, 32'h55);
        tick();
        tx_busy = 1;
        tick();
        chk("pre_reset_irq", 32'(irq), 32'h1);
        chk("pre_reset_data", 32'(tx_data), 32'h55);
        reset = 1;
        #1;
        chk("rst_tx_start", 32'(tx_start), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_tx_data", 32'(tx_data), 32'h0);
        peek(CON, d); chk("rst_con", d, 32'h0);
        tx_busy = 0;
        tick();
        reset = 0;
        tick();
        peek(CON, d); chk("post_rst_con", d, 32'h0);
        chk("post_rst_start", 32'(tx_start), 32'h0);
        peek(RXD, d); chk("post_rst_rxd", d, 32'h0);

        // Randomized RX traffic against a queue model
        ovr = 0;
        for (int i = 0; i < 300; i++) begin
            bit         do_rd, do_rv, do_clr, popm, fullm;
            logic [7:0] b;
            do_rd  = ($urandom_range(0, 9) < 4);
            do_rv  = ($urandom_range(0, 9) < 5);
            do_clr = !do_rd && ($urandom_range(0, 9) == 0);
            b      = 8'($urandom);
            addr = do_rd ? RXD : CON; rd = do_rd; wr = do_clr; wdata = 32'h20;
            rx_valid = do_rv; rx_data = b;
            #1;
            if (do_rd) chk("rand_rxd", rdata, (q.size() > 0) ? 32'(q[0]) : 32'h0);
            popm  = do_rd && (q.size() > 0);
            fullm = (q.size() == DEPTH);
            if (popm) void'(q.pop_front());
            if (do_rv && (!fullm || popm)) q.push_back(b);
            if (do_rv && fullm && !popm) ovr = 1;
            else if (do_clr)              ovr = 0;
            tick();
            rd = 0; wr = 0; rx_valid = 0;
            peek(CON, d);
            chk("rand_con", d, {26'b0, ovr, 1'b0, (q.size() > 0), 3'b0});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_bus_ctrl.md
UART_BUS_CTRL -- requirements
Module: uart_bus_ctrl

Interface
REQ-001 SHALL have parameter RX_DEPTH, default 4, RX FIFO depth in bytes (power of 2, 2..16).
REQ-002 SHALL have parameter BASE, default 32'h40000018, address of the first register. TXD is at BASE, RXD at BASE+4 and CON at BASE+8.
REQ-003 SHALL have port sysclk  in  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port addr  in  32  CPU peripheral byte address.
REQ-006 SHALL have port wdata  in  32  CPU write data.
REQ-007 SHALL have port wr  in  1  CPU write strobe, one cycle per access.
REQ-008 SHALL have port rd  in  1  CPU read strobe, one cycle per access.
REQ-009 SHALL have port rdata  out  32  read data, combinational.
REQ-010 SHALL have port rx_data  in  8  byte from the UART receiver.
REQ-011 SHALL have port rx_valid  in  1  one-cycle strobe that qualifies rx_data.
REQ-012 SHALL have port tx_busy  in  1  UART transmitter busy flag.
REQ-013 SHALL have port tx_data  out  8  byte sent to the UART transmitter.
REQ-014 SHALL have port tx_start  out  1  one-cycle transmit request.
REQ-015 SHALL have port irq  out  1  level interrupt to the CPU.

Function
REQ-016 SHALL use this CON layout:
  - bit0 rx_ie, RW
  - bit1 tx_ie, RW
  - bit2 tx_done, sticky, write-1-to-clear
  - bit3 rx_avail, RO, FIFO not empty
  - bit4 tx_full, RO, TX holding register occupied
  - bit5 rx_ovr, sticky, write-1-to-clear
  - bits31:6 read as 0
REQ-017 SHALL drive rdata combinationally when rd=1 and addr matches a register:
  - TXD returns {24'b0, last byte written}
  - RXD returns {24'b0, FIFO head}
  - CON returns CON
  - rdata = 0 otherwise.
REQ-018 SHALL pop the RX FIFO at the clock edge ending a read of RXD; an RXD read while the FIFO is empty returns 0 and pops nothing.
REQ-019 SHALL push rx_data on rx_valid=1 when the FIFO is not full; when full, the byte is dropped and rx_ovr is set.
REQ-020 SHALL perform both operations when a push and a pop occur in the same cycle, including when the FIFO is full: count unchanged, rx_ovr not set.
REQ-021 SHALL wrap the FIFO read/write pointers modulo RX_DEPTH; order SHALL be strict FIFO.
REQ-022 SHALL load wdata[7:0] into the TX holding register on a write to TXD while tx_full=0 and set tx_full; a TXD write while tx_full=1 SHALL be ignored.
REQ-023 SHALL run a TX state machine with states IDLE, START, WAIT_ACK and WAIT_DONE:
  - IDLE -> START when tx_full=1 and tx_busy=0.
  - START lasts one cycle: tx_start=1, tx_data=holding byte, tx_full cleared; then -> WAIT_ACK.
  - WAIT_ACK -> WAIT_DONE when tx_busy=1.
  - WAIT_DONE -> IDLE when tx_busy=0, setting tx_done in the same cycle.
REQ-024 SHALL hold tx_data stable from START until the next START.
REQ-025 SHALL allow a new TXD write as soon as tx_full=0, i.e. while WAIT_ACK or WAIT_DONE is active, giving one byte of double buffering.
REQ-026 SHALL give set priority over clear when a W1C write coincides with a tx_done or rx_ovr set event in the same cycle.
REQ-027 SHALL drive irq = (rx_ie & rx_avail) | (tx_ie & tx_done), combinational from registered state.
REQ-028 SHALL ignore writes to RXD and to unmapped addresses, and SHALL ignore rd/wr when the address does not match any register.
REQ-029 SHALL have a latency of 1 cycle from a TXD write to tx_start when the transmitter is idle; the rx_valid push SHALL be visible in rx_avail on the next cycle.

Reset
REQ-030 SHALL, while reset=1:
  - clear the FIFO pointers and count
  - clear CON to 0
  - clear the TX holding register and tx_data to 0
  - place the TX state machine in IDLE
  - drive tx_start=0 and irq=0.
REQ-031 SHALL let reset asserted mid-transmission abandon the byte without setting tx_done; the transmitter itself is reset separately.

Verification
REQ-032 SHALL cover RX ordering: rx_valid with 8'h96, then 8'hB9, then 8'h1E -> three RXD reads return 32'h96, 32'hB9, 32'h1E; a fourth read returns 0 and rx_avail=0.
REQ-033 SHALL cover overrun: 5 rx_valid pulses of 8'h01..8'h05 with RX_DEPTH=4 and no reads -> rx_ovr=1, reads return 01..04; writing CON=32'h20 clears rx_ovr.
REQ-034 SHALL cover TX sequencing: write TXD=8'h69 with tx_busy=0 -> tx_start pulses exactly one cycle later with tx_data=8'h69; the bench models tx_busy high for 10 cycles -> tx_done=1 after tx_busy falls; irq=1 only if tx_ie=1.
REQ-035 SHALL cover double buffering: write 8'h69 then 8'h46 during WAIT_DONE, then 8'hAA while tx_full=1 -> 8'hAA is ignored; the second tx_start carries 8'h46 only after tx_busy falls.
REQ-036 SHALL cover simultaneous full push/pop: FIFO full, RXD read coincident with rx_valid=8'h7E -> no overrun, 8'h7E becomes the last entry.
REQ-037 SHALL cover reset mid-operation: reset asserted in WAIT_DONE with 2 bytes in the FIFO -> all outputs 0 immediately, rx_avail=0, tx_done=0.
